// File: rtl/jpeg_decoder_input_ctrl.sv
// jpeg_decoder_input_ctrl
// Fill controller for the JPEG input FIFO. A start command (byte address,
// byte length) is turned into word-aligned burst read requests. FIFO space
// is reserved for every burst when it is issued, so returned beats can always
// be pushed. The FIFO is flushed when a job starts and when a job is aborted.
//
// Optional build macro JPEG_DECODER_INPUT_CTRL_4K_EN: when defined, bursts are
// clipped so that no request crosses a 4 KB address boundary.

module jpeg_decoder_input_ctrl #(
    parameter int BURST_WORDS     = 16,
    parameter int FIFO_DEPTH      = 1024,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] src_addr_i,
    input  logic [31:0] src_len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        req_valid_o,
    input  logic        req_accept_i,
    output logic [31:0] req_addr_o,
    output logic [7:0]  req_len_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_data_i,
    input  logic        resp_last_i,
    output logic        resp_accept_o,
    output logic [31:0] fifo_data_o,
    output logic        fifo_push_o,
    input  logic        fifo_accept_i,
    input  logic [10:0] fifo_level_i,
    output logic        fifo_flush_o
);

    // DONE and AFLUSH are one-cycle states that carry the done and
    // abort-flush pulses while busy_o is still high.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLUSH  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ABORT  = 3'd5;
    localparam logic [2:0] S_AFLUSH = 3'd6;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [31:0] addr_r;
    logic [30:0] remaining_r;
    logic [11:0] inflight_r;
    logic [2:0]  outstanding_r;
    logic        req_valid_r;
    logic [31:0] req_addr_r;
    logic [7:0]  req_len_r;
    logic        busy_r;
    logic        done_r;
    logic        flush_r;

    logic [8:0]  len_s;
    logic        fit_s;
    logic        can_issue_s;
    logic        req_fire_s;
    logic [8:0]  fire_len_s;
    logic        resp_accept_s;
    logic        push_s;
    logic        beat_s;
    logic        last_s;
    logic        job_start_s;
    logic [32:0] words_sum_s;
    logic [30:0] words_s;
    logic        inflight_dec_s;
    logic        outstanding_dec_s;
    logic        unused_s;

`ifdef JPEG_DECODER_INPUT_CTRL_4K_EN
    logic [10:0] words_to_4k_s;
`endif

    // Low address bits carry no information: the job start is word aligned.
    assign unused_s = ^src_addr_i[1:0];

    // Job length rounded up to whole words; 33 bits so a length near 4 GB cannot wrap.
    assign words_sum_s = {1'b0, src_len_i} + 33'd3;
    assign words_s     = words_sum_s[32:2];

    assign job_start_s = (state_r == S_IDLE) && (state_nxt_s == S_FLUSH);
    assign req_fire_s  = req_valid_r & req_accept_i;
    assign fire_len_s  = {1'b0, req_len_r} + 9'd1;

    // Length of the next burst: BURST_WORDS or whatever is left, optionally clipped at 4 KB.
    always_comb begin
        if (remaining_r < 31'(BURST_WORDS)) begin
            len_s = remaining_r[8:0];
        end else begin
            len_s = 9'(BURST_WORDS);
        end
`ifdef JPEG_DECODER_INPUT_CTRL_4K_EN
        words_to_4k_s = 11'd1024 - {1'b0, addr_r[11:2]};
        if ({2'b00, len_s} > words_to_4k_s) begin
            len_s = words_to_4k_s[8:0];
        end else begin
            len_s = len_s;
        end
`endif
    end

    // FIFO reservation: current occupancy plus words already promised plus this burst.
    assign fit_s = ({21'd0, fifo_level_i} + {20'd0, inflight_r} + {23'd0, len_s})
                   <= 32'(FIFO_DEPTH - 1);

    // A new request is loaded only when none is pending, so a pending one stays stable.
    assign can_issue_s = (state_r == S_ISSUE) && !abort_i && !req_valid_r
                         && (remaining_r != 31'd0)
                         && ({29'd0, outstanding_r} < 32'(MAX_OUTSTANDING))
                         && fit_s;

    // Response path: pass-through to the FIFO normally, swallow beats while aborting.
    always_comb begin
        case (state_r)
            S_IDLE: begin
                resp_accept_s = 1'b0;
                push_s        = 1'b0;
            end
            S_ABORT, S_AFLUSH: begin
                resp_accept_s = 1'b1;
                push_s        = 1'b0;
            end
            default: begin
                resp_accept_s = fifo_accept_i;
                push_s        = resp_valid_i & fifo_accept_i;
            end
        endcase
    end

    assign beat_s            = resp_valid_i & resp_accept_s;
    assign last_s            = beat_s & resp_last_i;
    assign inflight_dec_s    = beat_s && (inflight_r != 12'd0);
    assign outstanding_dec_s = last_s && (outstanding_r != 3'd0);

    // Next-state selection; abort wins over everything in the active states.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_nxt_s = S_FLUSH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (abort_i) begin
                    state_nxt_s = S_ABORT;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort_i) begin
                    state_nxt_s = S_ABORT;
                end else if (remaining_r == 31'd0) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_nxt_s = S_ABORT;
                end else if ((inflight_r == 12'd0) && (outstanding_r == 3'd0)) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            S_ABORT: begin
                if (!req_valid_r && (outstanding_r == 3'd0)) begin
                    state_nxt_s = S_AFLUSH;
                end else begin
                    state_nxt_s = S_ABORT;
                end
            end
            S_AFLUSH: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register with status outputs decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            flush_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != S_IDLE);
            done_r  <= (state_nxt_s == S_DONE);
            flush_r <= (state_nxt_s == S_FLUSH) || (state_nxt_s == S_AFLUSH);
        end
    end

    // Job bookkeeping: address cursor, words left, reserved words and open bursts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_r        <= 32'd0;
            remaining_r   <= 31'd0;
            inflight_r    <= 12'd0;
            outstanding_r <= 3'd0;
        end else if (job_start_s) begin
            addr_r        <= {src_addr_i[31:2], 2'b00};
            remaining_r   <= words_s;
            inflight_r    <= 12'd0;
            outstanding_r <= 3'd0;
        end else begin
            if (req_fire_s) begin
                addr_r      <= addr_r + {21'd0, fire_len_s, 2'b00};
                remaining_r <= remaining_r - {22'd0, fire_len_s};
            end else begin
                addr_r      <= addr_r;
                remaining_r <= remaining_r;
            end
            inflight_r    <= inflight_r
                             + (req_fire_s ? {3'd0, fire_len_s} : 12'd0)
                             - (inflight_dec_s ? 12'd1 : 12'd0);
            outstanding_r <= outstanding_r
                             + {2'b00, req_fire_s}
                             - {2'b00, outstanding_dec_s};
        end
    end

    // Request register: held until accepted, reloaded only when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid_r <= 1'b0;
            req_addr_r  <= 32'd0;
            req_len_r   <= 8'd0;
        end else if (req_fire_s) begin
            req_valid_r <= 1'b0;
        end else if (can_issue_s) begin
            req_valid_r <= 1'b1;
            req_addr_r  <= addr_r;
            req_len_r   <= 8'(len_s - 9'd1);
        end else begin
            req_valid_r <= req_valid_r;
        end
    end

    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign fifo_flush_o  = flush_r;
    assign req_valid_o   = req_valid_r;
    assign req_addr_o    = req_addr_r;
    assign req_len_o     = req_len_r;
    assign resp_accept_o = resp_accept_s;
    assign fifo_push_o   = push_s;
    assign fifo_data_o   = resp_data_i;

endmodule
